// File: rtl/text_buffer.sv
// 16x16 character-code store for the text overlay: a byte-stream writer with a
// hardware cursor, a self-clearing sequence, and a registered read-first lookup port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | writing CLEAR_CODE at clr_addr_q each cycle, 0..255; busy
// ST_IDLE  | in_ready high; accepted bytes write/move the cursor
module text_buffer #(
    parameter logic [6:0] CLEAR_CODE = 7'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_yx,
    output logic [6:0] char_code,
    input  logic       in_valid,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic [7:0] cursor_yx,
    output logic       busy
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [6:0] CODE_BS = 7'h08;
    localparam logic [6:0] CODE_LF = 7'h0A;
    localparam logic [6:0] CODE_FF = 7'h0C;
    localparam logic [6:0] CODE_CR = 7'h0D;
    localparam logic [6:0] CODE_DEL = 7'h7F;

    state_t     state_q, state_d;
    logic [7:0] clr_addr_q, clr_addr_d;
    logic [7:0] cursor_q, cursor_d;
    logic [6:0] char_code_q;

    logic [6:0] mem [256];
    logic       we;
    logic [7:0] waddr;
    logic [6:0] wdata;

    logic [6:0] code;
    logic       printable;
    logic       unused_in_msb;

    // Bit 7 of the incoming byte carries no meaning here.
    assign code          = in_byte[6:0];
    assign unused_in_msb = in_byte[7];
    assign printable     = (code >= 7'h20) && (code != CODE_DEL);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cursor_d   = cursor_q;
        we         = 1'b0;
        waddr      = clr_addr_q;
        wdata      = CLEAR_CODE;

        case (state_q)
            ST_CLEAR: begin
                we         = 1'b1;
                clr_addr_d = clr_addr_q + 8'd1;
                if (clr_addr_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    if (printable) begin
                        we       = 1'b1;
                        waddr    = cursor_q;
                        wdata    = code;
                        cursor_d = cursor_q + 8'd1;
                    end else begin
                        case (code)
                            CODE_LF: cursor_d = {cursor_q[7:4] + 4'd1, 4'h0};
                            CODE_CR: cursor_d = {cursor_q[7:4], 4'h0};
                            CODE_BS: begin
                                if (cursor_q != 8'h00) begin
                                    we       = 1'b1;
                                    waddr    = cursor_q - 8'd1;
                                    cursor_d = cursor_q - 8'd1;
                                end
                            end
                            CODE_FF: begin
                                cursor_d   = 8'h00;
                                clr_addr_d = 8'h00;
                                state_d    = ST_CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= 8'h00;
            cursor_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            cursor_q   <= cursor_d;
        end
    end

    // Array storage is left unreset so it maps onto block RAM; the clear
    // sequence provides the defined contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_code_q <= 7'h00;
        end else begin
            char_code_q <= mem[char_yx];
        end
    end

    assign char_code = char_code_q;
    assign cursor_yx = cursor_q;
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_text_buffer.sv
// Directed-plus-random bench for text_buffer: a flat array/cursor model of the
// screen is updated per accepted byte and compared against RAM sweeps and the cursor.
module tb_text_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] char_yx;
    logic [6:0] char_code;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic [7:0] cursor_yx;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] m_mem [256];
    logic [7:0] m_cur;

    text_buffer #(.CLEAR_CODE(7'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .char_yx   (char_yx),
        .char_code (char_code),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .cursor_yx (cursor_yx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 256; a++) m_mem[a] = 7'h20;
        m_cur = 8'h00;
    endtask

    // Screen semantics: row-major 16x16 grid, cursor = row*16 + col.
    task automatic model_apply(input logic [7:0] b);
        int c;
        int row;
        c   = int'(b) % 128;
        row = int'(m_cur) / 16;
        if (c >= 32 && c <= 126) begin
            m_mem[m_cur] = 7'(c);
            m_cur = 8'((int'(m_cur) + 1) % 256);
        end else if (c == 10) begin
            m_cur = 8'(((row + 1) % 16) * 16);
        end else if (c == 13) begin
            m_cur = 8'(row * 16);
        end else if (c == 8) begin
            if (m_cur != 8'h00) begin
                m_cur = 8'(int'(m_cur) - 1);
                m_mem[m_cur] = 7'h20;
            end
        end else if (c == 12) begin
            model_clear();
        end
    endtask

    function automatic logic [7:0] rand_print();
        return {1'($urandom_range(0, 1)), 7'($urandom_range(32, 126))};
    endfunction

    // Called at a negedge; leaves in_valid high so calls can run back to back.
    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", 32'(in_ready), 32'h1);
        in_valid = 1'b1;
        in_byte  = b;
        @(negedge clk);
        model_apply(b);
        if (b[6:0] == 7'h0C) in_valid = 1'b0;
        check("cursor", 32'(cursor_yx), 32'(m_cur));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_cell(input logic [7:0] a, output logic [6:0] v);
        char_yx = a;
        @(negedge clk);
        v = char_code;
    endtask

    task automatic sweep(input string tag);
        logic [6:0] v;
        for (int a = 0; a < 256; a++) begin
            read_cell(8'(a), v);
            check(tag, 32'(v), 32'(m_mem[a]));
        end
    endtask

    task automatic count_busy(input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            if (busy === 1'b1) cnt++;
            @(negedge clk);
        end
        check(tag, 32'(cnt), 32'd256);
        check({tag, "_ready"}, 32'(in_ready), 32'h1);
    endtask

    initial begin
        logic [6:0] v;
        logic [7:0] b;
        int cnt;

        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; char_yx = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_char_code", 32'(char_code), 32'h0);
        check("rst_cursor", 32'(cursor_yx), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        model_clear();
        rst = 1'b0;
        count_busy("init_busy_cycles");
        sweep("init_sweep");

        send(8'h41); send(8'h42); idle();
        check("ab_cursor", 32'(cursor_yx), 32'h02);
        read_cell(8'h00, v); check("ab_cell0", 32'(v), 32'h41);
        read_cell(8'h01, v); check("ab_cell1", 32'(v), 32'h42);

        repeat (8'h33) send(rand_print());
        idle();
        check("pre_ctrl_cursor", 32'(cursor_yx), 32'h35);
        send(8'h0A); check("lf_cursor", 32'(cursor_yx), 32'h40);
        send(8'h0D); check("cr_cursor", 32'(cursor_yx), 32'h40);
        send(8'h08); check("bs_cursor", 32'(cursor_yx), 32'h3F);
        idle();
        read_cell(8'h3F, v); check("bs_cell", 32'(v), 32'h20);

        repeat (300) begin
            if ($urandom_range(0, 1) == 1) b = rand_print();
            else b = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 31))};
            if (b[6:0] == 7'h0C) b = 8'h7F;
            send(b);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        sweep("mixed_sweep");

        while (m_cur != 8'hFF) send(rand_print());
        send(8'h5A); idle();
        check("wrap_cursor", 32'(cursor_yx), 32'h00);
        read_cell(8'hFF, v); check("wrap_cell", 32'(v), 32'h5A);
        send(8'h08); idle();
        check("bs_zero_cursor", 32'(cursor_yx), 32'h00);
        sweep("bs_zero_sweep");

        repeat (256) send(8'h58);
        idle();
        sweep("fill_sweep");
        send(8'h0C);
        check("ff_busy", 32'(busy), 32'h1);
        in_valid = 1'b1;
        in_byte  = 8'h4D;
        cnt = 0;
        while (in_ready !== 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("ff_ready_low_cycles", 32'(cnt), 32'd256);
        check("ff_cursor", 32'(cursor_yx), 32'h00);
        @(negedge clk);
        in_valid = 1'b0;
        model_apply(8'h4D);
        check("held_cursor", 32'(cursor_yx), 32'h01);
        sweep("ff_sweep");

        while (m_cur != 8'h10) send(rand_print());
        idle();
        char_yx  = 8'h10;
        in_valid = 1'b1;
        in_byte  = 8'h51;
        @(negedge clk);
        in_valid = 1'b0;
        model_apply(8'h51);
        check("rw_old", 32'(char_code), 32'h20);
        @(negedge clk);
        check("rw_new", 32'(char_code), 32'h51);

        send(8'h0C);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'h1);
        check("midrst_cursor", 32'(cursor_yx), 32'h0);
        check("midrst_char_code", 32'(char_code), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        count_busy("midrst_busy_cycles");
        sweep("midrst_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
# text_buffer

Character-code store for the on-screen text rectangle: holds a 16x16 grid of 7-bit ASCII codes, accepts a byte stream from a control/keyboard source through a valid/ready handshake with a hardware cursor, and answers the character-position lookups issued by the character draw stage. The registered `char_code` output goes to the font ROM address logic, `{char_code, char_line}`. The font ROM's `char_pixels` then feeds the draw stage.

## Interface
- `CLEAR_CODE`, default 7'h20, code written to every cell on reset and on form-feed.

- `clk`  in  1  pixel clock shared with the draw pipeline.
- `rst`  in  1  reset; one clock; asynchronous, active-high.
- `char_yx`  in  8  read address {row[3:0], col[3:0]} from the draw stage.
- `char_code`  out  7  code stored at `char_yx`, registered.
- `in_valid`  in  1  source presents `in_byte`.
- `in_byte`  in  8  ASCII byte or control code.
- `in_ready`  out  1  buffer can accept a byte this cycle.
- `cursor_yx`  out  8  current write position {row, col}.
- `busy`  out  1  clear sequence in progress.

## Operation
- Storage: 256 x 7-bit RAM, one synchronous write port and one synchronous read port. RAM contents are not reset. Cleared contents come from the clear sequence.
- State machine: CLEAR and IDLE.
  - Reset forces CLEAR with `clr_addr`=0.
  - CLEAR writes `CLEAR_CODE` at `clr_addr` and increments it every cycle. After writing address 255, it moves to IDLE.
  - In IDLE, `in_ready`=1. A byte is accepted in any cycle where `in_valid && in_ready`.
- Accepted byte handling, decided on bits [6:0] with `in_byte[7]` ignored:
  - 0x20..0x7E: write code at `cursor_yx`, then `cursor_yx` = `cursor_yx`+1 mod 256. Wrap from 0xFF goes to 0x00, with no scrolling.
  - 0x0A (LF): row = row+1 mod 16, col = 0. No write.
  - 0x0D (CR): col = 0. No write.
  - 0x08 (BS): if `cursor_yx` != 0, `cursor_yx` = `cursor_yx`-1 and write `CLEAR_CODE` at the new position in the same cycle. At 0x00 the byte has no effect.
  - 0x0C (FF): `cursor_yx` = 0, then enter CLEAR at the next edge.
  - Any other code: accepted and discarded, with no write and no cursor change.
- Read port: `char_code` <= RAM[`char_yx`] on every edge, regardless of state. It is read-first: if the read and a write hit the same address in the same cycle, `char_code` returns the old data.
- Signal definitions:
  - `busy` = (state == CLEAR).
  - `in_ready` = (state == IDLE).
  - `cursor_yx` is registered.

## Timing
- Reset values: `char_code`=0, `cursor_yx`=0, `in_ready`=0, `busy`=1, state CLEAR, `clr_addr`=0.
- Clear duration: exactly 256 cycles from the first clk edge after reset deassertion. `in_ready` rises on the cycle after address 255 is written.
- FF timing:
  - The FF is accepted at edge N, and `in_ready` drops after edge N.
  - Clear writes occur at edges N+1..N+256.
  - `in_ready` is 1 again after edge N+256.
- Read latency: 1 cycle from `char_yx` to `char_code`. A new address is accepted every cycle with no stalls. The draw stage gives one cycle to the char lookup and one to the font ROM.
- Cursor update and RAM write take effect at the same edge that accepts the byte. Back-to-back bytes are accepted every cycle in IDLE.
- `rst` asserted mid-clear or mid-stream abandons the operation immediately and restarts the full clear from address 0. The cursor returns to 0.
- `in_valid` while `busy`: the byte is not consumed, and the source must hold it until `in_ready`.

## Test plan
- Reset, then hold `in_valid`=0 for 300 cycles.
  - `busy` must stay 1 for exactly 256 cycles.
  - A sweep of `char_yx` 0x00..0xFF must read 0x20 on every address.
- Send "AB" on consecutive cycles from cursor 0.
  - Reading 0x00 and 0x01 must return 0x41 and 0x42.
  - `cursor_yx` must be 0x02.
- With the cursor at 0x35, send 0x0A, then 0x0D, then BS.
  - The cursor must step 0x35 -> 0x40 -> 0x40 -> 0x3F.
  - Reading 0x3F must return 0x20.
- Wrap: set the cursor to 0xFF via 255 printable bytes, then send 'Z'.
  - Cell 0xFF must read 0x5A, and the cursor must be 0x00.
  - BS at 0x00 must leave all cells and the cursor unchanged.
- Send FF after filling cells with 'X'.
  - `in_ready` must be low for 256 cycles.
  - All cells must read 0x20 afterwards, and the cursor must be 0.
  - A byte held on `in_valid` during the clear must be accepted only afterwards, at cell 0x00.
- Same-cycle read/write: write 'Q' at 0x10 while `char_yx`=0x10.
  - `char_code` must show the old 0x20 first, then 0x51 on the next read.
  - Asserting `rst` mid-clear must restart the 256-cycle clear.
